// File: rtl/mode_counter_pkg.sv
// Shared mode encoding for mode_counter and its next-state logic.
package mode_counter_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_UP       = 2'd0,
        MODE_DOWN     = 2'd1,
        MODE_MOD_UP   = 2'd2,
        MODE_MOD_DOWN = 2'd3
    } mode_e;

endpackage

// File: rtl/mode_counter_next.sv
// Combinational step, wrap and terminal-count decode for mode_counter.
// Optional saturation is built only when MODE_COUNTER_SAT_EN is defined.
module mode_counter_next
    import mode_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] count,
    input  mode_e            mode,
    input  logic [WIDTH-1:0] limit,
`ifdef MODE_COUNTER_SAT_EN
    input  logic             saturate,
`endif
    output logic [WIDTH-1:0] next_count,
    output logic             step_wrap,
    output logic             tc
);

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    logic [WIDTH-1:0] count_inc;
    logic [WIDTH-1:0] count_dec;

    assign count_inc = count + ONE;
    assign count_dec = count - ONE;

`ifdef MODE_COUNTER_SAT_EN
    logic [WIDTH-1:0] sat_value;

    // End value the counter parks at instead of wrapping.
    always_comb begin
        sat_value = '0;
        case (mode)
            MODE_UP:     sat_value = ALL_ONES;
            MODE_MOD_UP: sat_value = limit;
            default:     sat_value = '0;
        endcase
    end
`endif

    // A step wraps exactly when the terminal count is showing.
    always_comb begin
        next_count = count;
        step_wrap  = 1'b0;
        tc         = 1'b0;
        case (mode)
            MODE_UP: begin
                tc         = (count == ALL_ONES);
                next_count = count_inc;
            end
            MODE_DOWN: begin
                tc         = (count == '0);
                next_count = count_dec;
            end
            MODE_MOD_UP: begin
                tc         = (count >= limit);
                next_count = tc ? '0 : count_inc;
            end
            MODE_MOD_DOWN: begin
                tc = (count == '0);
                if (tc || (count > limit)) begin
                    next_count = limit;
                end else begin
                    next_count = count_dec;
                end
            end
            default: begin
                tc         = 1'b0;
                next_count = count;
            end
        endcase
        step_wrap = tc;
`ifdef MODE_COUNTER_SAT_EN
        if (saturate && tc) begin
            next_count = sat_value;
            step_wrap  = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/mode_counter.sv
// Up/down counter with four modes, modulo limit, parallel load and wrap/tc flags.
// Define MODE_COUNTER_SAT_EN to add the saturate input.
module mode_counter
    import mode_counter_pkg::*;
#(
    parameter int unsigned     WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]  limit,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_value,
`ifdef MODE_COUNTER_SAT_EN
    input  logic              saturate,
`endif
    output logic [WIDTH-1:0]  count,
    output logic              tc,
    output logic              wrap
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] step_count;
    logic             step_wrap;

    mode_counter_next #(
        .WIDTH(WIDTH)
    ) u_next (
        .count      (count_q),
        .mode       (mode_e'(mode)),
        .limit      (limit),
`ifdef MODE_COUNTER_SAT_EN
        .saturate   (saturate),
`endif
        .next_count (step_count),
        .step_wrap  (step_wrap),
        .tc         (tc)
    );

    // Load beats enable; otherwise hold with wrap cleared.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (load) begin
            count_d = load_value;
        end else if (enable) begin
            count_d = step_count;
            wrap_d  = step_wrap;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= RESET_VALUE;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_mode_counter.sv
// Scoreboard bench for mode_counter (WIDTH=4): directed plan plus random stimulus.
module tb_mode_counter;

    localparam int W    = 4;
    localparam int MAXV = (1 << W) - 1;
    localparam int RV   = 0;

    logic         clock;
    logic         reset;
    logic         enable;
    logic [1:0]   mode;
    logic [W-1:0] limit;
    logic         load;
    logic [W-1:0] load_value;
    logic         saturate;
    logic [W-1:0] count;
    logic         tc;
    logic         wrap;

    mode_counter #(
        .WIDTH       (W),
        .RESET_VALUE (W'(RV))
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .mode       (mode),
        .limit      (limit),
        .load       (load),
        .load_value (load_value),
`ifdef MODE_COUNTER_SAT_EN
        .saturate   (saturate),
`endif
        .count      (count),
        .tc         (tc),
        .wrap       (wrap)
    );

`ifdef MODE_COUNTER_SAT_EN
    localparam bit SAT_BUILD = 1'b1;
`else
    localparam bit SAT_BUILD = 1'b0;
`endif

    typedef struct {
        int step;
        int cnt;
        bit wr;
        bit tcv;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   step_no = 0;
    int   m_count = RV;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic bit tc_of(input int c, input int md, input int lim);
        case (md)
            0:       return c == MAXV;
            1:       return c == 0;
            2:       return c >= lim;
            default: return c == 0;
        endcase
    endfunction

    // Apply one cycle of inputs and predict the state after the next edge.
    task automatic step(input bit rst, input bit ld, input int lv, input bit en,
                        input int md, input int lim, input bit sat);
        exp_t e;
        int   nc;
        bit   nw;
        @(negedge clock);
        reset      = rst;
        load       = ld;
        load_value = W'(lv);
        enable     = en;
        mode       = 2'(md);
        limit      = W'(lim);
        saturate   = sat;
        nc = m_count;
        nw = 1'b0;
        if (rst) begin
            nc = RV;
        end else if (ld) begin
            nc = lv;
        end else if (en) begin
            case (md)
                0: begin nw = (m_count == MAXV); nc = (m_count + 1) % (MAXV + 1); end
                1: begin nw = (m_count == 0);    nc = (m_count + MAXV) % (MAXV + 1); end
                2: begin nw = (m_count >= lim);  nc = nw ? 0 : m_count + 1; end
                default: begin
                    nw = (m_count == 0);
                    if (nw || m_count > lim) nc = lim;
                    else nc = m_count - 1;
                end
            endcase
            if (sat && nw) begin
                nw = 1'b0;
                case (md)
                    0:       nc = MAXV;
                    2:       nc = lim;
                    default: nc = 0;
                endcase
            end
        end
        m_count = nc;
        step_no++;
        e.step = step_no;
        e.cnt  = nc;
        e.wr   = nw;
        e.tcv  = tc_of(nc, md, lim);
        exp_q.push_back(e);
    endtask

    // Monitor: compare the DUT outputs after every edge against the queued prediction.
    always begin
        exp_t e;
        @(posedge clock);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (int'(count) != e.cnt) begin
                errors++;
                $display("FAIL count step=%0d actual=%0d required=%0d", e.step, count, e.cnt);
            end
            checks++;
            if (wrap != e.wr) begin
                errors++;
                $display("FAIL wrap step=%0d actual=%0b required=%0b", e.step, wrap, e.wr);
            end
            checks++;
            if (tc != e.tcv) begin
                errors++;
                $display("FAIL tc step=%0d actual=%0b required=%0b", e.step, tc, e.tcv);
            end
        end
    end

    initial begin
        int md, lim;
        reset = 1'b1; load = 1'b0; load_value = '0; enable = 1'b0;
        mode = 2'd0; limit = '0; saturate = 1'b0;

        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 17; i++) step(0, 0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 2, 2, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 2, 2, 0);
        step(0, 1, 0, 0, 3, 2, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 3, 2, 0);
        step(0, 1, 9, 0, 3, 5, 0);
        step(0, 0, 0, 1, 3, 5, 0);
        step(0, 1, 12, 1, 0, 5, 0);
        step(0, 0, 0, 0, 0, 5, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 2, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 3, 0, 0);
        step(0, 1, 7, 0, 0, 0, 0);
        step(1, 1, 3, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        if (SAT_BUILD) begin
            step(0, 1, 15, 0, 0, 0, 0);
            for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0, 1);
            step(0, 1, 0, 0, 3, 4, 0);
            for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 3, 4, 1);
            step(0, 1, 11, 0, 2, 6, 0);
            step(0, 0, 0, 1, 2, 6, 1);
        end

        for (int i = 0; i < 400; i++) begin
            md  = int'($urandom_range(0, 3));
            lim = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 4));
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
                 int'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), md, lim,
                 SAT_BUILD && ($urandom_range(0, 2) == 0));
        end

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d pending required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mode_counter.md
# mode_counter

Parametrised up/down counter with four counting modes, a programmable modulo limit, parallel load and wrap/terminal-count flags. It is the general-width successor of the 2-bit mode-select counter and serves as the shared event/sequence counter for control logic in the CPU (loop counters, stall timers, round-robin pointers).

## Interface
- WIDTH, 8, counter width in bits (≥2)
- RESET_VALUE, 0, value loaded into count on reset (WIDTH bits)

- clock  input  1  rising-edge clock; the only clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  advance count by one step this cycle
- mode  input  2  0 = free up, 1 = free down, 2 = modulo up, 3 = modulo down
- limit  input  WIDTH  modulo limit (count range 0..limit in modes 2/3)
- load  input  1  parallel load request
- load_value  input  WIDTH  value written on load
- saturate  input  1  present only with MODE_COUNTER_SAT_EN; hold at end instead of wrapping
- count  output  WIDTH  current count (registered)
- tc  output  1  terminal count: next enabled step wraps (or saturates), combinational decode of count/mode/limit
- wrap  output  1  registered one-cycle pulse: previous cycle's step wrapped

## Operation
- Priority per cycle: reset > load > enable > hold.
- reset: count <= RESET_VALUE, wrap <= 0.
- load: count <= load_value regardless of enable or mode; wrap <= 0; load_value above limit is accepted unchanged.
- enable, mode 0: count+1 mod 2^WIDTH; wrap when count was all-ones.
- enable, mode 1: count-1 mod 2^WIDTH; wrap when count was 0.
- enable, mode 2: if count ≥ limit, count <= 0 and wrap; else count+1.
- enable, mode 3: if count == 0, count <= limit and wrap; if count > limit, count <= limit, no wrap; else count-1.
- Not enabled and no load: count holds; wrap <= 0.
- tc: mode 0 count==all-ones; mode 1 count==0; mode 2 count≥limit; mode 3 count==0. Independent of enable.
- limit == 0 in modes 2/3: count forced/held at 0, every enabled step asserts wrap.
- mode and limit may change any cycle; the new values govern the very next edge, no internal state beyond count/wrap.

## Timing
- count updates on the clock edge where load/enable is sampled; latency 1 cycle.
- wrap is high exactly the cycle after a wrapping step; back-to-back wraps (limit 0, enable held) give continuous wrap.
- tc is valid in the same cycle as count, changes combinationally with mode/limit.
- Reset mid-count: next edge count = RESET_VALUE, wrap = 0; tc reflects RESET_VALUE against current mode.
- Reset values: count = RESET_VALUE, wrap = 0, tc = decode (1 for RESET_VALUE 0 in modes 1/3).

## Configuration
- MODE_COUNTER_SAT_EN defined: saturate port exists; when saturate=1 any step that would wrap instead holds count at its current end value (all-ones, 0, limit, 0 respectively; mode 2 with count>limit goes to limit), wrap is not asserted, tc still asserted at the end value.
- Undefined: no saturate port; behaviour is always wrapping as above.

## Structure
- Shared package: mode encoding constants (MODE_UP, MODE_DOWN, MODE_MOD_UP, MODE_MOD_DOWN) and mode typedef.
- One sub-module, mode_counter_next: combinational next-value, wrap and tc computation from count/mode/limit(/saturate); top holds only the count and wrap registers and priority muxing.

## Test plan
- WIDTH=4, reset, mode 0, enable 17 cycles -> count 0..15,0,1; wrap high exactly one cycle after 15->0; tc high at 15.
- mode 1 from 0, enable 2 cycles -> count 15,14; wrap pulse after first step; tc high at 0.
- mode 2, limit 2, enable 7 cycles -> 1,2,0,1,2,0,1; mode 3, limit 2 from 0 -> 2,1,0,2.
- load_value 9, mode 3, limit 5, enable -> 5 (no wrap); load and enable same cycle -> load_value wins; limit 0 mode 2 -> count 0, wrap continuous.
- Reset asserted mid-count at count 7 with load and enable high -> next count RESET_VALUE, wrap 0.
- With MODE_COUNTER_SAT_EN, saturate 1, mode 0 at 15, enable 3 cycles -> count stays 15, wrap never, tc 1; mode 3 at 0 stays 0.
